// File: rtl/multi_pulse_counter.sv
// Multi-channel pulse edge counter. Each channel input is synchronised and edge-decoded,
// then counted over a repeating window; every window close produces a snapshot and a valid strobe.
module multi_pulse_counter #(
    parameter int CH_NUM      = 4,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int WIN_W       = 24
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [CH_NUM-1:0]       i_pulse,
    input  logic                    i_en,
    input  logic [1:0]              i_edge_mode,
    input  logic                    i_sat_mode,
    input  logic [WIN_W-1:0]        i_win_len,
    output logic [CH_NUM*CNT_W-1:0] o_cnt,
    output logic [CH_NUM-1:0]       o_ovf,
    output logic                    o_valid,
    output logic                    o_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        COUNT = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CH_NUM-1:0]       sync_q [SYNC_STAGES];
    logic [CH_NUM-1:0]       hist_q;
    logic [CH_NUM-1:0]       sync_last;
    logic [CH_NUM-1:0]       edge_det;

    logic [CH_NUM*CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [CH_NUM-1:0]       ovf_q, ovf_d, ovf_inc;
    logic [WIN_W-1:0]        timer_q, timer_d, win_load;
    logic [CH_NUM*CNT_W-1:0] snap_cnt_q, snap_cnt_d;
    logic [CH_NUM-1:0]       snap_ovf_q, snap_ovf_d;
    logic                    valid_q, valid_d;

    // Synchroniser chain; runs regardless of FSM state so edges are never stale on entry to COUNT.
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    sync_q[gi] <= '0;
                end else if (gi == 0) begin
                    sync_q[gi] <= i_pulse;
                end else begin
                    sync_q[gi] <= sync_q[(gi == 0) ? 0 : gi-1];
                end
            end
        end
    endgenerate

    assign sync_last = sync_q[SYNC_STAGES-1];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            hist_q <= '0;
        end else begin
            hist_q <= sync_last;
        end
    end

    always_comb begin
        case (i_edge_mode)
            2'b00:   edge_det = sync_last & ~hist_q;
            2'b01:   edge_det = ~sync_last & hist_q;
            default: edge_det = sync_last ^ hist_q;
        endcase
    end

    // Per-channel value after this cycle's edge, with wrap or saturate at all-ones.
    generate
        for (gi = 0; gi < CH_NUM; gi++) begin : g_chan
            logic [CNT_W-1:0] cur;
            logic [CNT_W-1:0] nxt;
            logic             ovf_nxt;

            assign cur = cnt_q[gi*CNT_W +: CNT_W];

            always_comb begin
                nxt     = cur;
                ovf_nxt = ovf_q[gi];
                if (edge_det[gi]) begin
                    if (&cur) begin
                        ovf_nxt = 1'b1;
                        if (!i_sat_mode) begin
                            nxt = '0;
                        end
                    end else begin
                        nxt = cur + 1'b1;
                    end
                end
            end

            assign cnt_inc[gi*CNT_W +: CNT_W] = nxt;
            assign ovf_inc[gi]                = ovf_nxt;
        end
    endgenerate

    assign win_load = (i_win_len == '0) ? WIN_W'(1) : i_win_len;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        timer_d    = timer_q;
        snap_cnt_d = snap_cnt_q;
        snap_ovf_d = snap_ovf_q;
        valid_d    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                ovf_d = '0;
                if (i_en) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                cnt_d   = '0;
                ovf_d   = '0;
                timer_d = win_load;
                state_d = i_en ? COUNT : IDLE;
            end
            COUNT: begin
                if (!i_en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    ovf_d   = '0;
                end else if (timer_q == WIN_W'(1)) begin
                    // Window close: snapshot includes this cycle's edges, next window starts clean.
                    snap_cnt_d = cnt_inc;
                    snap_ovf_d = ovf_inc;
                    valid_d    = 1'b1;
                    cnt_d      = '0;
                    ovf_d      = '0;
                    timer_d    = win_load;
                end else begin
                    cnt_d   = cnt_inc;
                    ovf_d   = ovf_inc;
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ovf_q      <= '0;
            timer_q    <= '0;
            snap_cnt_q <= '0;
            snap_ovf_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            timer_q    <= timer_d;
            snap_cnt_q <= snap_cnt_d;
            snap_ovf_q <= snap_ovf_d;
            valid_q    <= valid_d;
        end
    end

    assign o_cnt   = snap_cnt_q;
    assign o_ovf   = snap_ovf_q;
    assign o_valid = valid_q;
    assign o_busy  = (state_q == COUNT);

endmodule
